// File: rtl/bv_match_encoder_if.sv
// Vector-in / result-out bundle for bv_match_encoder.
// match_count exists only when BV_MATCH_COUNT_EN is defined.
interface bv_match_encoder_if #(
  parameter int BV_W  = 64,
  parameter int IDX_W = 6
);
  logic             bv_in_valid;
  logic [BV_W-1:0]  bv_in;
  logic             bv_in_ready;
  logic             rule_valid;
  logic             rule_hit;
  logic [IDX_W-1:0] rule_id;
`ifdef BV_MATCH_COUNT_EN
  logic [IDX_W:0]   match_count;
`endif

  modport master (
    output bv_in_valid, bv_in,
    input  bv_in_ready, rule_valid, rule_hit, rule_id
`ifdef BV_MATCH_COUNT_EN
    , input match_count
`endif
  );

  modport slave (
    input  bv_in_valid, bv_in,
    output bv_in_ready, rule_valid, rule_hit, rule_id
`ifdef BV_MATCH_COUNT_EN
    , output match_count
`endif
  );
endinterface

// File: rtl/bv_match_encoder.sv
// Lowest-set-bit encoder for a matched-rule vector, scanned one chunk per cycle.
// BV_MATCH_COUNT_EN: full scan with popcount on match_count, no early exit.
module bv_match_encoder #(
  parameter int BV_W    = 64,
  parameter int CHUNK_W = 16,
  parameter int IDX_W   = 6
) (
  input logic              clk,
  input logic              reset,
  bv_match_encoder_if.slave bus
);
  localparam int NCH   = BV_W / CHUNK_W;
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LSB_W = $clog2(CHUNK_W);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                        state;
  logic [PTR_W-1:0]              ptr;
  logic [NCH-1:0][CHUNK_W-1:0]   shadow;
  logic                          rule_valid_q, rule_hit_q;
  logic [IDX_W-1:0]              rule_id_q;

  logic [CHUNK_W-1:0] chunk;
  logic               nz, last;
  logic [IDX_W-1:0]   cur_id;

  function automatic logic [LSB_W-1:0] lsb_idx(input logic [CHUNK_W-1:0] v);
    lsb_idx = '0;
    for (int i = CHUNK_W-1; i >= 0; i--)
      if (v[i]) lsb_idx = LSB_W'(i);
  endfunction

  assign chunk  = shadow[ptr];
  assign nz     = |chunk;
  assign last   = (ptr == PTR_W'(NCH-1));
  // Chunk pointer forms the high bits of the index directly; no adder needed.
  assign cur_id = IDX_W'({ptr, lsb_idx(chunk)});

  assign bus.bv_in_ready = (state == IDLE);
  assign bus.rule_valid  = rule_valid_q;
  assign bus.rule_hit    = rule_hit_q;
  assign bus.rule_id     = rule_id_q;

`ifdef BV_MATCH_COUNT_EN
  localparam int CNT_W = IDX_W + 1;

  logic             found;
  logic [IDX_W-1:0] found_id;
  logic [CNT_W-1:0] acc, match_count_q;
  logic [LSB_W:0]   pop;

  function automatic logic [LSB_W:0] popcnt(input logic [CHUNK_W-1:0] v);
    popcnt = '0;
    for (int i = 0; i < CHUNK_W; i++)
      popcnt = popcnt + (LSB_W+1)'(v[i]);
  endfunction

  assign pop             = popcnt(chunk);
  assign bus.match_count = match_count_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      shadow       <= '0;
      rule_valid_q <= 1'b0;
      rule_hit_q   <= 1'b0;
      rule_id_q    <= '0;
`ifdef BV_MATCH_COUNT_EN
      found         <= 1'b0;
      found_id      <= '0;
      acc           <= '0;
      match_count_q <= '0;
`endif
    end else begin
      rule_valid_q <= 1'b0;
      case (state)
        IDLE: if (bus.bv_in_valid) begin
          shadow <= bus.bv_in;
          ptr    <= '0;
          state  <= SCAN;
`ifdef BV_MATCH_COUNT_EN
          found    <= 1'b0;
          found_id <= '0;
          acc      <= '0;
`endif
        end
        SCAN: begin
`ifdef BV_MATCH_COUNT_EN
          if (!found && nz) begin
            found    <= 1'b1;
            found_id <= cur_id;
          end
          if (last) begin
            rule_valid_q  <= 1'b1;
            rule_hit_q    <= found | nz;
            rule_id_q     <= found ? found_id : (nz ? cur_id : '0);
            match_count_q <= acc + CNT_W'(pop);
            state         <= IDLE;
          end else begin
            acc <= acc + CNT_W'(pop);
            ptr <= ptr + PTR_W'(1);
          end
`else
          if (nz) begin
            rule_valid_q <= 1'b1;
            rule_hit_q   <= 1'b1;
            rule_id_q    <= cur_id;
            state        <= IDLE;
          end else if (last) begin
            rule_valid_q <= 1'b1;
            rule_hit_q   <= 1'b0;
            rule_id_q    <= '0;
            state        <= IDLE;
          end else begin
            ptr <= ptr + PTR_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bv_match_encoder.sv
// Directed bench for bv_match_encoder; expected values are hand-computed
// for both the default build and BV_MATCH_COUNT_EN.
module tb_bv_match_encoder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;

  bv_match_encoder_if #(.BV_W(64), .IDX_W(6)) bus ();

  bv_match_encoder #(.BV_W(64), .CHUNK_W(16), .IDX_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef BV_MATCH_COUNT_EN
  localparam bit CNT = 1'b1;
`else
  localparam bit CNT = 1'b0;
`endif

  // Latency of a vector whose first non-zero chunk is c (0..3); all-zero uses 3.
  function automatic int exp_k(input int c);
    return CNT ? 4 : c + 1;
  endfunction

  // Present a vector at negedge; returns after the acceptance edge (+1).
  task automatic accept(input logic [63:0] v, input string name);
    @(negedge clk);
    checks++;
    if (bus.bv_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_before_accept: got %b want 1", name, bus.bv_in_ready);
    end
    bus.bv_in_valid = 1'b1;
    bus.bv_in       = v;
    @(posedge clk);
    #1;
    bus.bv_in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk);
      #1;
      if (bus.rule_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (bus.bv_in_ready !== 1'b1 || bus.rule_valid !== 1'b0 || bus.rule_hit !== 1'b0 || bus.rule_id !== 6'd0) begin
      errors++;
      $display("FAIL reset_state: ready=%b valid=%b hit=%b id=%0d want 1/0/0/0",
               bus.bv_in_ready, bus.rule_valid, bus.rule_hit, bus.rule_id);
    end
`ifdef BV_MATCH_COUNT_EN
    checks++;
    if (bus.match_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_match_count: got %0d want 0", bus.match_count);
    end
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_bit0();
    int lat;
    accept(64'h0000_0000_0000_0001, "bit0");
    wait_result(lat);
    checks++;
    if (lat != exp_k(0) || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd0) begin
      errors++;
      $display("FAIL bit0: lat=%0d hit=%b id=%0d want lat=%0d hit=1 id=0", lat, bus.rule_hit, bus.rule_id, exp_k(0));
    end
    @(posedge clk); #1;
    checks++;
    if (bus.rule_valid !== 1'b0) begin
      errors++;
      $display("FAIL bit0_pulse_width: rule_valid=%b want 0", bus.rule_valid);
    end
  endtask

  task automatic test_bit63();
    int lat = -1;
    int busy_bad = 0;
    accept(64'h8000_0000_0000_0000, "bit63");
    for (int c = 1; c <= 12; c++) begin
      if (bus.bv_in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
      if (bus.rule_valid === 1'b1) begin lat = c; break; end
    end
    checks++;
    if (lat != 4 || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd63) begin
      errors++;
      $display("FAIL bit63: lat=%0d hit=%b id=%0d want lat=4 hit=1 id=63", lat, bus.rule_hit, bus.rule_id);
    end
    checks++;
    if (busy_bad != 0 || bus.bv_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bit63_ready: busy cycles with ready=1: %0d, ready at result=%b want 0 and 1", busy_bad, bus.bv_in_ready);
    end
    // Result fields must hold after the pulse.
    @(posedge clk); #1;
    checks++;
    if (bus.rule_valid !== 1'b0 || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd63) begin
      errors++;
      $display("FAIL bit63_hold: valid=%b hit=%b id=%0d want 0/1/63", bus.rule_valid, bus.rule_hit, bus.rule_id);
    end
  endtask

  task automatic test_zero();
    int lat;
    accept(64'h0, "zero");
    wait_result(lat);
    checks++;
    if (lat != 4 || bus.rule_hit !== 1'b0 || bus.rule_id !== 6'd0) begin
      errors++;
      $display("FAIL zero: lat=%0d hit=%b id=%0d want lat=4 hit=0 id=0", lat, bus.rule_hit, bus.rule_id);
    end
`ifdef BV_MATCH_COUNT_EN
    checks++;
    if (bus.match_count !== 7'd0) begin
      errors++;
      $display("FAIL zero_match_count: got %0d want 0", bus.match_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int lat;
    accept(64'h0000_0010_0001_0000, "b2b");
    bus.bv_in_valid = 1'b1;
    bus.bv_in       = 64'h1;
    wait_result(lat);
    checks++;
    if (lat != exp_k(1) || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd16) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d hit=%b id=%0d want lat=%0d hit=1 id=16", lat, bus.rule_hit, bus.rule_id, exp_k(1));
    end
`ifdef BV_MATCH_COUNT_EN
    checks++;
    if (bus.match_count !== 7'd2) begin
      errors++;
      $display("FAIL b2b_match_count: got %0d want 2", bus.match_count);
    end
`endif
    checks++;
    if (bus.bv_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_in_result_cycle: got %b want 1", bus.bv_in_ready);
    end
    @(posedge clk); #1;  // second vector accepted on this edge
    bus.bv_in_valid = 1'b0;
    checks++;
    if (bus.rule_valid !== 1'b0 || bus.bv_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: valid=%b ready=%b want 0/0", bus.rule_valid, bus.bv_in_ready);
    end
    wait_result(lat);
    checks++;
    if (lat != exp_k(0) || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd0) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d hit=%b id=%0d want lat=%0d hit=1 id=0", lat, bus.rule_hit, bus.rule_id, exp_k(0));
    end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    int lat;
    accept(64'h8000_0000_0000_0000, "rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.rule_valid !== 1'b0 || bus.rule_hit !== 1'b0 || bus.rule_id !== 6'd0 || bus.bv_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_outputs: valid=%b hit=%b id=%0d ready=%b want 0/0/0/1",
               bus.rule_valid, bus.rule_hit, bus.rule_id, bus.bv_in_ready);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (bus.rule_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || bus.bv_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_no_result: pulses=%0d ready=%b want 0 and 1", seen, bus.bv_in_ready);
    end
    accept(64'h4, "rst_next");
    wait_result(lat);
    checks++;
    if (lat != exp_k(0) || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd2) begin
      errors++;
      $display("FAIL rst_next: lat=%0d hit=%b id=%0d want lat=%0d hit=1 id=2", lat, bus.rule_hit, bus.rule_id, exp_k(0));
    end
  endtask

  task automatic test_multi_bit();
    int lat;
    accept(64'hF000_0000_0000_0003, "multi");
    wait_result(lat);
    checks++;
    if (lat != exp_k(0) || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd0) begin
      errors++;
      $display("FAIL multi: lat=%0d hit=%b id=%0d want lat=%0d hit=1 id=0", lat, bus.rule_hit, bus.rule_id, exp_k(0));
    end
`ifdef BV_MATCH_COUNT_EN
    checks++;
    if (bus.match_count !== 7'd6) begin
      errors++;
      $display("FAIL multi_match_count: got %0d want 6", bus.match_count);
    end
`endif
    accept(64'h0000_0300_0000_0000, "mid_chunk");
    wait_result(lat);
    checks++;
    if (lat != exp_k(2) || bus.rule_hit !== 1'b1 || bus.rule_id !== 6'd40) begin
      errors++;
      $display("FAIL mid_chunk: lat=%0d hit=%b id=%0d want lat=%0d hit=1 id=40", lat, bus.rule_hit, bus.rule_id, exp_k(2));
    end
  endtask

  initial begin
    bus.bv_in_valid = 1'b0;
    bus.bv_in       = '0;
    test_reset();
    test_bit0();
    test_bit63();
    test_zero();
    test_back_to_back();
    test_reset_mid_scan();
    test_multi_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bv_match_encoder.md
# bv_match_encoder

Consumer end of the packet-classification bit-vector path: accepts a 64-bit matched-rule vector (valid-qualified, bit i set = rule i matches) from the field-AND stage and reduces it to the highest-priority matching rule. Lowest set bit index wins. The vector is scanned one 16-bit chunk per cycle, with early exit on the first non-zero chunk. A single-vector input register with a ready handshake provides back-pressure; the result leaves as a one-cycle valid pulse.

## Interface
- BV_W, 64, matched-rule vector width; power of two, multiple of CHUNK_W.
- CHUNK_W, 16, bits examined per scan cycle; power of two.
- IDX_W, 6, rule index width; must equal log2(BV_W).
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- bv_in_valid  input  1  bv_in holds a vector this cycle.
- bv_in  input  BV_W  matched-rule vector; bit i = rule i.
- bv_in_ready  output  1  block can accept a vector this cycle.
- rule_valid  output  1  one-cycle pulse; rule_hit/rule_id are valid.
- rule_hit  output  1  at least one bit was set in the vector.
- rule_id  output  IDX_W  index of lowest set bit; 0 when rule_hit=0.
- match_count  output  IDX_W+1  popcount of vector (only with BV_MATCH_COUNT_EN).

## Operation
- Reset: clk, reset exactly as decided above. Reset is asynchronous, active-low.
- States:
  - IDLE: bv_in_ready=1. On bv_in_valid=1, capture bv_in into shadow register, clear chunk pointer ptr=0, go to SCAN.
  - SCAN: bv_in_ready=0. Examine chunk ptr (bits ptr*CHUNK_W +: CHUNK_W).
    - Chunk non-zero: rule_id = ptr*CHUNK_W + lowest set bit in chunk; rule_hit=1; rule_valid=1; go to IDLE.
    - Chunk zero and ptr = BV_W/CHUNK_W-1: rule_hit=0, rule_id=0, rule_valid=1; go to IDLE.
    - Otherwise: ptr increments, stay in SCAN.
- bv_in_ready is decoded directly from state==IDLE. It is not registered.
- bv_in_valid while bv_in_ready=0 is ignored; no capture, no error. Upstream must hold or drop the vector.
- rule_hit/rule_id hold their last value until the next result; only rule_valid pulses.
- Priority within a chunk: the lowest bit index wins.
- rule_id arithmetic: ptr (log2(BV_W/CHUNK_W) bits) concatenated with in-chunk index (log2(CHUNK_W) bits). No carries.

## Timing
- Reset values: rule_valid=0, rule_hit=0, rule_id=0, match_count=0, state=IDLE, ptr=0, shadow=0.
- bv_in_ready reads 1 whenever state is IDLE, including during reset. No capture occurs while reset is low.
- Acceptance edge is A. The result resolves at edge A+k, where k = index of the first non-zero chunk + 1, range 1..4.
  - rule_valid is high in the cycle following A+k.
  - All-zero vector: k=4.
- State is IDLE in the rule_valid cycle. A new vector offered in that cycle is accepted, giving back-to-back throughput of one vector per k+1 cycles.
- Reset asserted mid-scan: the scan is abandoned immediately. All outputs return to reset values. No rule_valid is emitted for the aborted vector.
- The shadow register is not updated during SCAN. Changes on bv_in during SCAN have no effect.

## Configuration
- BV_MATCH_COUNT_EN defined:
  - Adds the match_count port.
  - Early exit is disabled: SCAN always runs all BV_W/CHUNK_W chunks, so k=4 for every vector.
  - Per-chunk popcount accumulates into match_count.
  - rule_hit/rule_id report the first non-zero chunk seen, latched without later overwrite.
  - match_count is updated in the same cycle as rule_valid.
- BV_MATCH_COUNT_EN undefined: no match_count port, no popcount logic, early exit active.

## Test plan
- After reset, present bv_in=64'h0000_0000_0000_0001 for one cycle -> rule_valid pulses 1 cycle after acceptance; rule_hit=1, rule_id=0.
- bv_in=64'h8000_0000_0000_0000 -> rule_valid 4 cycles after acceptance; rule_hit=1, rule_id=63. bv_in_ready=0 for those 4 cycles.
- bv_in=64'h0 -> rule_valid after 4 cycles; rule_hit=0, rule_id=0.
  - With BV_MATCH_COUNT_EN: match_count=0.
- bv_in=64'h0000_0010_0001_0000, then hold bv_in_valid=1 with bv_in=64'h1:
  - First result: rule_id=16 after 2 cycles.
  - Second vector accepted in the rule_valid cycle; rule_id=0 one cycle later.
- Accept 64'h8000_0000_0000_0000, assert reset 2 cycles later -> no rule_valid; outputs 0; bv_in_ready=1 after release; next vector 64'h4 gives rule_id=2.
- With BV_MATCH_COUNT_EN, bv_in=64'hF000_0000_0000_0003 -> rule_valid after 4 cycles; rule_id=0, match_count=6.
